// File: rtl/wb_rr_arbiter.sv
// Wishbone bus arbiter for NUM_MASTERS masters.
// Supports round-robin or fixed priority, a one-hot grant, and an optional hold limit.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int GNT_W       = $clog2(NUM_MASTERS),
  parameter int RR_MODE     = 1,
  parameter int MAX_HOLD    = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_MASTERS-1:0] CYC_I,
  output logic [GNT_W-1:0]       GNT,
  output logic [NUM_MASTERS-1:0] GNT_ONEHOT,
  output logic                   CYC,
  output logic                   PREEMPT
);

  localparam int unsigned N      = NUM_MASTERS;
  localparam int          HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q, state_d;
  logic [GNT_W-1:0]       gnt_q, gnt_d;
  logic [GNT_W-1:0]       last_q, last_d;
  logic [NUM_MASTERS-1:0] onehot_q, onehot_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   preempt_q, preempt_d;

  logic [NUM_MASTERS-1:0] others;
  logic [GNT_W-1:0]       win_all, win_oth;
  int unsigned            start;

  // First set bit at or after 'from', wrapping modulo N.
  function automatic logic [GNT_W-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                            input int unsigned from);
    logic [GNT_W-1:0] w;
    logic             found;
    int unsigned      idx;
    w     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (from + i) % N;
      if (!found && req[idx]) begin
        w     = GNT_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    start   = (RR_MODE != 0) ? ((32'(last_q) + 32'd1) % N) : 32'd0;
    others  = CYC_I & ~onehot_q;
    win_all = pick(CYC_I, start);
    win_oth = pick(others, start);

    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    onehot_d  = onehot_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|CYC_I) begin
          state_d           = OWNED;
          gnt_d             = win_all;
          last_d            = win_all;
          onehot_d          = '0;
          onehot_d[win_all] = 1'b1;
          hold_d            = '0;
        end
      end
      OWNED: begin
        if (!CYC_I[gnt_q]) begin
          if (|CYC_I) begin
            gnt_d             = win_all;
            last_d            = win_all;
            onehot_d          = '0;
            onehot_d[win_all] = 1'b1;
            hold_d            = '0;
          end else begin
            state_d  = IDLE;
            onehot_d = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_q >= HOLD_LIM) && (|others)) begin
          // >= so a competitor arriving after the counter saturated still forces a handover
          gnt_d             = win_oth;
          last_d            = win_oth;
          onehot_d          = '0;
          onehot_d[win_oth] = 1'b1;
          hold_d            = '0;
          preempt_d         = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= GNT_W'(N - 1);
      onehot_q  <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      onehot_q  <= onehot_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign GNT        = gnt_q;
  assign GNT_ONEHOT = onehot_q;
  assign PREEMPT    = preempt_q;
  assign CYC        = (state_q == OWNED) & CYC_I[gnt_q];

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: four instances cover RR, fixed priority,
// hold-limit preemption and a 6-master configuration.
module tb_wb_rr_arbiter;

  logic clk, rst;

  logic [3:0] cyc_a, oh_a, cyc_b, oh_b, cyc_h, oh_h;
  logic [1:0] gnt_a, gnt_b, gnt_h;
  logic       c_a, p_a, c_b, p_b, c_h, p_h;
  logic [5:0] cyc_n, oh_n;
  logic [2:0] gnt_n;
  logic       c_n, p_n;

  wb_rr_arbiter #(.NUM_MASTERS(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
    .CLK(clk), .RST(rst), .CYC_I(cyc_a), .GNT(gnt_a), .GNT_ONEHOT(oh_a), .CYC(c_a), .PREEMPT(p_a));
  wb_rr_arbiter #(.NUM_MASTERS(4), .RR_MODE(0), .MAX_HOLD(0)) u_fix (
    .CLK(clk), .RST(rst), .CYC_I(cyc_b), .GNT(gnt_b), .GNT_ONEHOT(oh_b), .CYC(c_b), .PREEMPT(p_b));
  wb_rr_arbiter #(.NUM_MASTERS(4), .RR_MODE(1), .MAX_HOLD(4)) u_hold (
    .CLK(clk), .RST(rst), .CYC_I(cyc_h), .GNT(gnt_h), .GNT_ONEHOT(oh_h), .CYC(c_h), .PREEMPT(p_h));
  wb_rr_arbiter #(.NUM_MASTERS(6), .RR_MODE(1), .MAX_HOLD(0)) u_n6 (
    .CLK(clk), .RST(rst), .CYC_I(cyc_n), .GNT(gnt_n), .GNT_ONEHOT(oh_n), .CYC(c_n), .PREEMPT(p_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned dut;
    logic        rst;
    logic [5:0]  cyc;
    int unsigned gnt;
    logic [5:0]  oh;
    logic        cyco;
    logic        pre;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   vec_no = 0;

  function automatic void add(int unsigned d, logic r, logic [5:0] c, int unsigned g,
                              logic [5:0] o, logic co, logic p);
    vec_t v;
    v = '{dut: d, rst: r, cyc: c, gnt: g, oh: o, cyco: co, pre: p};
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    vec_t        e;
    int unsigned ag;
    logic [5:0]  aoh;
    logic        ac, ap;
    @(negedge clk);
    rst = v.rst;
    case (v.dut)
      0: cyc_a = v.cyc[3:0];
      1: cyc_b = v.cyc[3:0];
      2: cyc_h = v.cyc[3:0];
      default: cyc_n = v.cyc;
    endcase
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    case (e.dut)
      0: begin ag = 32'(gnt_a); aoh = {2'b00, oh_a}; ac = c_a; ap = p_a; end
      1: begin ag = 32'(gnt_b); aoh = {2'b00, oh_b}; ac = c_b; ap = p_b; end
      2: begin ag = 32'(gnt_h); aoh = {2'b00, oh_h}; ac = c_h; ap = p_h; end
      default: begin ag = 32'(gnt_n); aoh = oh_n; ac = c_n; ap = p_n; end
    endcase
    checks++;
    if (ag != e.gnt || aoh != e.oh || ac != e.cyco || ap != e.pre) begin
      failures++;
      $display("FAIL vec%0d dut%0d: got gnt=%0d oh=%b cyc=%b pre=%b, want gnt=%0d oh=%b cyc=%b pre=%b",
               vec_no, e.dut, ag, aoh, ac, ap, e.gnt, e.oh, e.cyco, e.pre);
    end
    vec_no++;
  endtask

  initial begin
    logic [3:0] c4;
    int unsigned m, prev;
    rst = 1'b1;
    cyc_a = '0; cyc_b = '0; cyc_h = '0; cyc_n = '0;

    // Hand-written: master 1 then 0, back-to-back handover, CYC falling mid-cycle
    apply('{dut: 0, rst: 1, cyc: 6'b0000, gnt: 0, oh: 6'b0000, cyco: 0, pre: 0});
    apply('{dut: 0, rst: 0, cyc: 6'b0010, gnt: 1, oh: 6'b0010, cyco: 1, pre: 0});
    apply('{dut: 0, rst: 0, cyc: 6'b0011, gnt: 1, oh: 6'b0010, cyco: 1, pre: 0});
    apply('{dut: 0, rst: 0, cyc: 6'b0011, gnt: 1, oh: 6'b0010, cyco: 1, pre: 0});
    @(negedge clk);
    cyc_a = 4'b0001;
    #1;
    checks++;
    if (c_a !== 1'b0) begin
      failures++;
      $display("FAIL cyc_drop_comb: got CYC=%b want 0", c_a);
    end
    apply('{dut: 0, rst: 0, cyc: 6'b0001, gnt: 0, oh: 6'b0001, cyco: 1, pre: 0});
    apply('{dut: 0, rst: 0, cyc: 6'b0001, gnt: 0, oh: 6'b0001, cyco: 1, pre: 0});
    apply('{dut: 0, rst: 0, cyc: 6'b0000, gnt: 0, oh: 6'b0000, cyco: 0, pre: 0});

    // RR fairness: each owner drops for one cycle after three granted cycles
    add(0, 1, 6'b0000, 0, 6'b0000, 0, 0);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      m  = 32'(k % 4);
      c4 = (k == 0) ? 4'b1111 : (4'b1111 & ~(4'b0001 << prev));
      add(0, 0, {2'b00, c4}, m, 6'b000001 << m, 1, 0);
      add(0, 0, 6'b001111, m, 6'b000001 << m, 1, 0);
      add(0, 0, 6'b001111, m, 6'b000001 << m, 1, 0);
      prev = m;
    end

    // Fixed priority: only 0 and 1 alternate, 2 wins once both go idle
    add(1, 1, 6'b0000, 0, 6'b0000, 0, 0);
    for (int k = 0; k < 5; k++) begin
      m  = 32'(k % 2);
      c4 = (k == 0) ? 4'b1111 : (4'b1111 & ~(4'b0001 << prev));
      add(1, 0, {2'b00, c4}, m, 6'b000001 << m, 1, 0);
      add(1, 0, 6'b001111, m, 6'b000001 << m, 1, 0);
      add(1, 0, 6'b001111, m, 6'b000001 << m, 1, 0);
      prev = m;
    end
    add(1, 0, 6'b001100, 2, 6'b000100, 1, 0);

    // MAX_HOLD=4: preempt exactly 4 edges after grant 0, then regrant 0
    add(2, 1, 6'b0000, 0, 6'b0000, 0, 0);
    add(2, 0, 6'b0001, 0, 6'b0001, 1, 0);
    add(2, 0, 6'b0001, 0, 6'b0001, 1, 0);
    add(2, 0, 6'b0101, 0, 6'b0001, 1, 0);
    add(2, 0, 6'b0101, 0, 6'b0001, 1, 0);
    add(2, 0, 6'b0101, 2, 6'b0100, 1, 1);
    add(2, 0, 6'b0101, 2, 6'b0100, 1, 0);
    add(2, 0, 6'b0001, 0, 6'b0001, 1, 0);
    for (int k = 0; k < 8; k++) add(2, 0, 6'b0001, 0, 6'b0001, 1, 0);

    // Six masters: RR wraps from 5 to 0
    add(3, 1, 6'b000000, 0, 6'b000000, 0, 0);
    add(3, 0, 6'b100000, 5, 6'b100000, 1, 0);
    add(3, 0, 6'b100001, 5, 6'b100000, 1, 0);
    add(3, 0, 6'b000001, 0, 6'b000001, 1, 0);
    add(3, 0, 6'b000000, 0, 6'b000000, 0, 0);

    // Mid-operation reset while master 2 owns the bus
    add(0, 1, 6'b0000, 0, 6'b0000, 0, 0);
    add(0, 0, 6'b0100, 2, 6'b0100, 1, 0);
    add(0, 0, 6'b0100, 2, 6'b0100, 1, 0);
    add(0, 1, 6'b0100, 0, 6'b0000, 0, 0);
    add(0, 0, 6'b0101, 0, 6'b0001, 1, 0);

    foreach (vecs[i]) apply(vecs[i]);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
